// File: rtl/u_marb.sv
// rtl/u_marb.sv - IFU/LSU single-port memory arbiter and transaction sequencer
module u_marb #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ifu_req,
  input  logic [AW-1:0]   ifu_addr,
  input  logic            ifu_kill,
  output logic            ifu_gnt,
  output logic            ifu_rvld,
  output logic [DW-1:0]   ifu_rdata,
  input  logic            lsu_req,
  input  logic            lsu_we,
  input  logic [AW-1:0]   lsu_addr,
  input  logic [DW-1:0]   lsu_wdata,
  input  logic [DW/8-1:0] lsu_be,
  output logic            lsu_gnt,
  output logic            lsu_rvld,
  output logic [DW-1:0]   lsu_rdata,
  output logic            lsu_pend,
  output logic            mem_req,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_be,
  input  logic            mem_gnt,
  input  logic            mem_rvld,
  input  logic [DW-1:0]   mem_rdata
);

  localparam int BW = DW / 8;
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] SCNT_MAX = SW'(STARVE_MAX);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [SW-1:0]   scnt_q, scnt_d;
  logic            owner_q, owner_d;    // 0 = IFU, 1 = LSU
  logic            killed_q, killed_d;
  logic            mem_we_q, mem_we_d;
  logic [AW-1:0]   mem_addr_q, mem_addr_d;
  logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
  logic [BW-1:0]   mem_be_q, mem_be_d;

  logic            ifu_cand;
  logic            resp_fire;

  assign ifu_cand = ifu_req & ~ifu_kill;

  // State and latched bus fields; reset drops any transaction in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      scnt_q      <= '0;
      owner_q     <= 1'b0;
      killed_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
    end else begin
      state_q     <= state_d;
      scnt_q      <= scnt_d;
      owner_q     <= owner_d;
      killed_q    <= killed_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
    end
  end

  // Arbitration in IDLE, bus handshake sequencing, kill tracking.
  always_comb begin
    state_d     = state_q;
    scnt_d      = scnt_q;
    owner_d     = owner_q;
    killed_d    = killed_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    ifu_gnt     = 1'b0;
    lsu_gnt     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (!rst) begin
          // LSU has priority unless the IFU has been passed over STARVE_MAX times.
          if (lsu_req && !(ifu_cand && scnt_q == SCNT_MAX)) begin
            lsu_gnt     = 1'b1;
            owner_d     = 1'b1;
            mem_we_d    = lsu_we;
            mem_addr_d  = lsu_addr;
            mem_wdata_d = lsu_wdata;
            mem_be_d    = lsu_be;
            state_d     = S_REQ;
            if (ifu_cand) begin
              scnt_d = (scnt_q == SCNT_MAX) ? SCNT_MAX : scnt_q + SW'(1);
            end
          end else if (ifu_cand) begin
            ifu_gnt     = 1'b1;
            owner_d     = 1'b0;
            mem_we_d    = 1'b0;
            mem_addr_d  = ifu_addr;
            mem_wdata_d = '0;
            mem_be_d    = {BW{1'b1}};
            state_d     = S_REQ;
            scnt_d      = '0;
          end
        end
      end
      S_REQ: begin
        if (ifu_kill && !owner_q) killed_d = 1'b1;
        if (mem_gnt) state_d = S_RESP;
      end
      S_RESP: begin
        if (ifu_kill && !owner_q) killed_d = 1'b1;
        if (mem_rvld) begin
          state_d  = S_IDLE;
          killed_d = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Response routing: rvld is a pass-through qualified by owner and kill state.
  always_comb begin
    resp_fire = (state_q == S_RESP) && mem_rvld && !rst;
    lsu_rvld  = resp_fire && owner_q;
    ifu_rvld  = resp_fire && !owner_q && !killed_q && !ifu_kill;
  end

  assign ifu_rdata = mem_rdata;
  assign lsu_rdata = mem_rdata;
  assign lsu_pend  = owner_q && (state_q != S_IDLE);

  assign mem_req   = (state_q == S_REQ);
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;

endmodule

// File: doc/u_marb.md
# u_marb

Single-port memory arbiter and transaction sequencer between the instruction fetch unit (IFU) and the load/store unit (LSU). It serializes both requesters onto one shared memory bus, with one transaction outstanding at a time. LSU has fixed priority, and a starvation guard guarantees IFU progress. Killed fetches, for example after a taken branch flush, complete on the bus but their response is dropped. It sits between the core pipeline stages and the memory port. Its `lsu_pend` output feeds the hazard unit's stall logic.

## Interface
- `AW`, default 32: address width.
- `DW`, default 32: data width. Byte-enable width is `DW/8`.
- `STARVE_MAX`, default 4: maximum consecutive LSU grants while IFU is waiting. Legal range is ≥1.

- `clk` in 1: clock. All state updates on the rising edge.
- `rst` in 1: synchronous reset, active-high.
- `ifu_req` in 1: fetch request. Held until `ifu_gnt`.
- `ifu_addr` in AW: fetch address.
- `ifu_kill` in 1: flush. Cancels the pending or outstanding fetch.
- `ifu_gnt` out 1: fetch accepted. Single-cycle pulse.
- `ifu_rvld` out 1: fetch data valid. Single-cycle pulse.
- `ifu_rdata` out DW: fetch data.
- `lsu_req` in 1: data request. Held until `lsu_gnt`.
- `lsu_we` in 1: 1 = store, 0 = load.
- `lsu_addr` in AW: data address.
- `lsu_wdata` in DW: store data.
- `lsu_be` in DW/8: byte enables.
- `lsu_gnt` out 1: data request accepted. Single-cycle pulse.
- `lsu_rvld` out 1: load data valid or store ack. Single-cycle pulse.
- `lsu_rdata` out DW: load data. Don't-care on a store ack.
- `lsu_pend` out 1: an LSU transaction is accepted and not yet answered.
- `mem_req` out 1: bus request. Held until `mem_gnt`.
- `mem_we` out 1: bus write.
- `mem_addr` out AW: bus address.
- `mem_wdata` out DW: bus write data.
- `mem_be` out DW/8: bus byte enables. All ones for fetches.
- `mem_gnt` in 1: bus accepted the request.
- `mem_rvld` in 1: bus response valid. Earliest one cycle after `mem_gnt`.
- `mem_rdata` in DW: bus read data.

## Operation
- FSM has three states:
  - IDLE: no transaction.
  - REQ: driving the bus request.
  - RESP: waiting for the bus response.
- IDLE, arbitration (combinational, same cycle):
  - An IFU candidate is `ifu_req & !ifu_kill`.
  - If only one candidate is present, it wins.
  - If both are present, LSU wins, unless `scnt == STARVE_MAX`, in which case IFU wins.
  - The winner gets its `*_gnt` pulse.
  - The winner's fields are latched into the `mem_*` registers; `owner` is latched (0 = IFU, 1 = LSU).
  - Next state is REQ.
- Starvation counter `scnt`, width `$clog2(STARVE_MAX+1)`:
  - On an LSU grant while `ifu_req & !ifu_kill`: `scnt+1`, saturating at `STARVE_MAX`.
  - On an IFU grant: `scnt = 0`.
  - Otherwise: hold.
- REQ:
  - `mem_req=1`, with fields stable from the registers.
  - On `mem_gnt`, go to RESP.
  - A request is never withdrawn.
- RESP:
  - On `mem_rvld`, route `mem_rdata` to the owner and go to IDLE.
  - The owner's `*_rvld` is a combinational pass-through of `mem_rvld`.
  - `*_rdata` is a combinational pass-through of `mem_rdata`.
- Kill:
  - `ifu_kill` while `owner==IFU` in REQ or RESP sets the `killed` flag.
  - With `killed` set, or `ifu_kill` in the response cycle itself, the fetch response is dropped: `ifu_rvld` stays 0.
  - The bus transaction still completes normally.
  - `killed` clears on return to IDLE.
  - `ifu_kill` has no effect on LSU transactions.
- `lsu_pend` is 1 from the cycle after `lsu_gnt` through the `lsu_rvld` cycle inclusive.
- No new grant is issued in the RESP→IDLE response cycle. Arbitration happens only in IDLE.

## Timing
- Reset (synchronous, takes effect at the edge with `rst=1`):
  - state = IDLE; `scnt`, `owner`, `killed` = 0.
  - `mem_req=0`; `mem_we`, `mem_addr`, `mem_wdata`, `mem_be` = 0.
  - `ifu_gnt`, `lsu_gnt`, `ifu_rvld`, `lsu_rvld`, `lsu_pend` = 0.
- Reset mid-transaction:
  - Arbiter returns to IDLE immediately.
  - Any late `mem_rvld` is ignored in IDLE; the owner sees no `*_rvld`.
- Best-case latency:
  - Cycle 0: request and `*_gnt` (IDLE).
  - Cycle 1: `mem_req` with `mem_gnt`.
  - Cycle 2: `mem_rvld` and `*_rvld`.
  - Cycle 3: IDLE, next grant possible.
  - Peak throughput is one transaction per 3 cycles.
- `mem_gnt` stalls extend REQ; `mem_rvld` stalls extend RESP. Both are unbounded.
- `mem_rvld` in REQ or IDLE is a protocol error and is ignored.
- Simultaneous `ifu_req` and `ifu_kill` in IDLE: no IFU grant. LSU may be granted.

## Test plan
- Reset, then a single IFU fetch at `0x100`:
  - `ifu_gnt` in cycle 0.
  - `mem_req=1` with `mem_addr=0x100` and `mem_be=0xF` in cycle 1, with `mem_gnt=1`.
  - `mem_rvld=1`, `mem_rdata=0xDEADBEEF` in cycle 2 → `ifu_rvld=1`, `ifu_rdata=0xDEADBEEF`.
  - Back in IDLE in cycle 3.
- LSU store `0x2000`, `wdata=0x55AA`, `be=0x3`:
  - `mem_we=1` with fields passed through.
  - `lsu_pend=1` from gnt+1 through the ack cycle.
  - `lsu_rvld` pulses once.
- `ifu_req` and `lsu_req` both held continuously, `STARVE_MAX=4`:
  - Grant order is L,L,L,L,I,L,L,L,L,I.
  - `scnt` resets after each IFU grant.
- IFU fetch accepted, `ifu_kill` pulsed while in REQ with `mem_gnt=0` for 3 cycles:
  - `mem_req` is held until `mem_gnt`.
  - The response arrives with `ifu_rvld=0`.
  - The next fetch's response is delivered normally.
- Bus stalls:
  - `mem_gnt` delayed 5 cycles → `mem_req` and all fields stay stable, and no new `*_gnt` is issued.
  - `rst` asserted in RESP → `mem_req=0` and state IDLE next cycle.
  - A stray `mem_rvld` after reset produces no `*_rvld`.
